// File: rtl/letc_pkg.sv
// rtl/letc_pkg.sv - shared LETC core widths and word/address types
package letc_pkg;

    localparam int PADDR_WIDTH = 32;
    localparam int WORD_WIDTH  = 32;

    typedef logic [WORD_WIDTH-1:0]  word_t;
    typedef logic [PADDR_WIDTH-1:0] paddr_t;

endpackage : letc_pkg

// File: rtl/letc_lutram_bank.sv
// rtl/letc_lutram_bank.sv - DEPTH x DWIDTH LUTRAM, per-lane write enables, async read
module letc_lutram_bank #(
    parameter int DEPTH  = 64,
    parameter int BWIDTH = 32,
    parameter int DWIDTH = 512,
    localparam int IW    = $clog2(DEPTH),
    localparam int LANES = DWIDTH / BWIDTH
) (
    input  logic              i_clk,
    input  logic              i_wen,
    input  logic [LANES-1:0]  i_wben,
    input  logic [IW-1:0]     i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [IW-1:0]     i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately unreset so this maps onto distributed RAM.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (i_wen && i_wben[k]) begin
                mem_q[i_waddr][k*BWIDTH +: BWIDTH] <= i_wdata[k*BWIDTH +: BWIDTH];
            end
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule : letc_lutram_bank

// File: rtl/letc_core_cache_refill_datapath.sv
// rtl/letc_core_cache_refill_datapath.sv - cache line refill datapath: line storage,
// word address counter and one-hot lane selector
module letc_core_cache_refill_datapath
    import letc_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int BWIDTH = 32,
    parameter int DWIDTH = 512,
    parameter int AWIDTH = PADDR_WIDTH,
    parameter int STEP   = 4,
    localparam int IW    = $clog2(DEPTH),
    localparam int LANES = DWIDTH / BWIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic              i_wen,
    input  logic [IW-1:0]     i_waddr,
    input  logic [BWIDTH-1:0] i_wdata,
    input  logic [IW-1:0]     i_raddr,
    output logic [DWIDTH-1:0] o_rdata,
    output logic [AWIDTH-1:0] o_addr,
    output logic [LANES-1:0]  o_wben,
    output logic              o_last
);

    generate
        if (DWIDTH % BWIDTH != 0) begin : g_bad_width
            $error("DWIDTH must be a multiple of BWIDTH");
        end
    endgenerate

    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [LANES-1:0]  wben_q, wben_d;

    // Load takes priority over a same-cycle write for both registers.
    always_comb begin
        addr_d = addr_q;
        if (i_load) begin
            addr_d = i_addr;
        end else if (i_wen) begin
            addr_d = addr_q + AWIDTH'(STEP);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // After the top lane is written the register drains to zero and stays idle.
    always_comb begin
        wben_d = wben_q;
        if (i_load) begin
            wben_d = LANES'(1);
        end else if (i_wen) begin
            wben_d = {wben_q[LANES-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wben_q <= '0;
        end else begin
            wben_q <= wben_d;
        end
    end

    letc_lutram_bank #(
        .DEPTH  (DEPTH),
        .BWIDTH (BWIDTH),
        .DWIDTH (DWIDTH)
    ) u_bank (
        .i_clk   (i_clk),
        .i_wen   (i_wen),
        .i_wben  (wben_q),
        .i_waddr (i_waddr),
        .i_wdata ({LANES{i_wdata}}),
        .i_raddr (i_raddr),
        .o_rdata (o_rdata)
    );

    assign o_addr = addr_q;
    assign o_wben = wben_q;
    assign o_last = wben_q[LANES-1];

endmodule : letc_core_cache_refill_datapath

// File: tb/tb_letc_core_cache_refill_datapath.sv
// tb/tb_letc_core_cache_refill_datapath.sv - self-checking bench for the refill datapath
module tb_letc_core_cache_refill_datapath;
    import letc_pkg::*;

    localparam int NL = 64;
    localparam int NW = 16;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_load = 1'b0;
    logic [31:0]  i_addr = '0;
    logic         i_wen = 1'b0;
    logic [5:0]   i_waddr = '0;
    logic [31:0]  i_wdata = '0;
    logic [5:0]   i_raddr = '0;
    logic [511:0] o_rdata;
    logic [31:0]  o_addr;
    logic [15:0]  o_wben;
    logic         o_last;

    letc_core_cache_refill_datapath dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (i_load),
        .i_addr  (i_addr),
        .i_wen   (i_wen),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .i_raddr (i_raddr),
        .o_rdata (o_rdata),
        .o_addr  (o_addr),
        .o_wben  (o_wben),
        .o_last  (o_last)
    );

    always #5 i_clk = ~i_clk;

    // Reference: words per line, a refill address, and the index of the next lane (16 = none).
    word_t  model [NL][NW];
    paddr_t m_addr = '0;
    int     m_lane = NW;
    int     passed = 0;
    int     total  = 0;

    function automatic logic [511:0] exp_line(input int idx);
        logic [511:0] r;
        for (int k = 0; k < NW; k++) r[k*32 +: 32] = model[idx][k];
        return r;
    endfunction

    function automatic logic [15:0] exp_wben();
        return (m_lane < NW) ? (16'd1 << m_lane) : 16'd0;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"}, 512'(o_addr), 512'(m_addr));
        check({tag, ".wben"}, 512'(o_wben), 512'(exp_wben()));
        check({tag, ".last"}, 512'(o_last), 512'(m_lane == NW - 1));
        check({tag, ".rdata"}, o_rdata, exp_line(int'(i_raddr)));
    endtask

    task automatic cyc(input logic ld, input logic we, input logic [31:0] a,
                       input logic [5:0] wa, input logic [31:0] wd, input logic [5:0] ra);
        i_load = ld; i_wen = we; i_addr = a; i_waddr = wa; i_wdata = wd; i_raddr = ra;
        @(posedge i_clk);
        if (we && m_lane < NW) model[wa][m_lane] = wd;
        if (ld) begin
            m_addr = a;
            m_lane = 0;
        end else if (we) begin
            m_addr = m_addr + 32'd4;
            if (m_lane < NW) m_lane++;
        end
        #1;
        i_load = 1'b0; i_wen = 1'b0;
    endtask

    task automatic fill_line(input int idx, input logic [31:0] a, input logic rnd, input logic [31:0] val);
        cyc(1'b1, 1'b0, a, 6'(idx), 32'd0, 6'(idx));
        for (int k = 0; k < NW; k++)
            cyc(1'b0, 1'b1, 32'd0, 6'(idx), rnd ? $urandom : val, 6'(idx));
    endtask

    initial begin
        logic [511:0] line3;
        word_t        old7;

        // Reset state
        @(posedge i_clk); #1;
        check("reset.addr", 512'(o_addr), 512'd0);
        check("reset.wben", 512'(o_wben), 512'd0);
        check("reset.last", 512'(o_last), 512'd0);
        i_rst_n = 1'b1;

        // Give every line known contents so the model covers the whole array.
        for (int l = 0; l < NL; l++) fill_line(l, $urandom, 1'b1, 32'd0);
        check_all("init");

        // Full line fill
        cyc(1'b1, 1'b0, 32'h8000_0040, 6'd5, 32'd0, 6'd5);
        check("fill.load_addr", 512'(o_addr), 512'h8000_0040);
        for (int k = 0; k < NW; k++) begin
            if (k == NW - 1) check("fill.last_before16", 512'(o_last), 512'd1);
            cyc(1'b0, 1'b1, 32'd0, 6'd5, 32'h1000 + 32'(k), 6'd5);
            check($sformatf("fill.addr%0d", k), 512'(o_addr), 512'(32'h8000_0044 + 32'(4 * k)));
        end
        check("fill.wben_after", 512'(o_wben), 512'd0);
        for (int k = 0; k < NW; k++)
            check($sformatf("fill.lane%0d", k), 512'(o_rdata[k*32 +: 32]), 512'(32'h1000 + 32'(k)));
        check_all("fill");

        // Lane isolation
        fill_line(3, 32'h0, 1'b0, 32'hAAAA_AAAA);
        cyc(1'b1, 1'b0, 32'h0, 6'd3, 32'd0, 6'd3);
        cyc(1'b0, 1'b1, 32'h0, 6'd3, 32'h5555_5555, 6'd3);
        cyc(1'b0, 1'b1, 32'h0, 6'd3, 32'h5555_5555, 6'd3);
        line3 = {{14{32'hAAAA_AAAA}}, {2{32'h5555_5555}}};
        check("iso.line3", o_rdata, line3);
        for (int l = 0; l < NL; l++) begin
            i_raddr = 6'(l); #1;
            check($sformatf("iso.line%0d", l), o_rdata, exp_line(l));
        end

        // Load priority: the write lands in lane 2 with the pre-load enable
        cyc(1'b1, 1'b1, 32'h100, 6'd3, 32'h1234_5678, 6'd3);
        check("prio.addr", 512'(o_addr), 512'h100);
        check("prio.wben", 512'(o_wben), 512'd1);
        check("prio.lane2", 512'(o_rdata[2*32 +: 32]), 512'h1234_5678);
        check_all("prio");

        // Counter wrap
        cyc(1'b1, 1'b0, 32'hFFFF_FFFC, 6'd9, 32'd0, 6'd9);
        cyc(1'b0, 1'b1, 32'h0, 6'd9, 32'hCAFE_0001, 6'd9);
        check("wrap.addr", 512'(o_addr), 512'h0);
        check_all("wrap");

        // Read-during-write on line 7, lane 0
        cyc(1'b1, 1'b0, 32'h700, 6'd7, 32'd0, 6'd7);
        old7 = model[7][0];
        i_wen = 1'b1; i_waddr = 6'd7; i_raddr = 6'd7; i_wdata = 32'hDEAD_BEEF;
        #1;
        check("rdw.before", 512'(o_rdata[31:0]), 512'(old7));
        cyc(1'b0, 1'b1, 32'h0, 6'd7, 32'hDEAD_BEEF, 6'd7);
        check("rdw.after", 512'(o_rdata[31:0]), 512'hDEAD_BEEF);
        check_all("rdw");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom,
                6'($urandom), $urandom, 6'($urandom));
            check_all($sformatf("rnd%0d", n));
        end

        // Asynchronous reset mid-refill, checked before any clock edge
        cyc(1'b1, 1'b0, 32'h2000, 6'd11, 32'd0, 6'd11);
        cyc(1'b0, 1'b1, 32'h0, 6'd11, 32'hBEEF_0011, 6'd11);
        #2;
        i_rst_n = 1'b0;
        #1;
        m_addr = '0;
        m_lane = NW;
        check("arst.addr", 512'(o_addr), 512'd0);
        check("arst.wben", 512'(o_wben), 512'd0);
        check("arst.last", 512'(o_last), 512'd0);
        check("arst.rdata", o_rdata, exp_line(11));
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        cyc(1'b0, 1'b1, 32'h0, 6'd11, 32'h0BAD_0BAD, 6'd11);
        check_all("arst.noop_write");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_letc_core_cache_refill_datapath
